// File: rtl/reaction_timer_ctrl.sv
// Reaction timer sequencer: arms the delay generator, lights GO, measures response in ms, tracks best time.
// Latency: start press -> ARMED on the same edge the rise is seen; press in GO -> result registered on that edge.
// Backpressure: none; buttons are level inputs edge-detected here, start is ignored while ARMED or GO.
module reaction_timer_ctrl #(
  parameter int unsigned TIMEOUT_MS = 9999  // must fit in 14 bits (<= 16383)
) (
  input  logic        clk_1ms,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic        delay_done,
  output logic        delay_start,
  output logic        go_led,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic        foul,
  output logic        timeout,
  output logic [13:0] best_ms,
  output logic [2:0]  state_dbg
);

  localparam logic [13:0] LP_TIMEOUT = 14'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_start_prev;
  logic        r_react_prev;
  logic [13:0] r_count;
  logic        w_start_rise;
  logic        w_react_rise;
  logic        w_enter_armed;
  logic        w_enter_foul;
  logic        w_enter_go;
  logic        w_press_hit;
  logic        w_timed_out;

  // Previous button levels reset high so a button held through reset gives no edge.
  assign w_start_rise = start_btn & ~r_start_prev;
  assign w_react_rise = react_btn & ~r_react_prev;

  // Moore outputs straight from the state register; reset drops delay_start immediately.
  assign delay_start = (r_state == S_ARMED);
  assign go_led      = (r_state == S_GO);
  assign state_dbg   = r_state;

  // State register.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the per-edge events that steer the datapath.
  always_comb begin
    w_next        = r_state;
    w_enter_armed = 1'b0;
    w_enter_foul  = 1'b0;
    w_enter_go    = 1'b0;
    w_press_hit   = 1'b0;
    w_timed_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_next        = S_ARMED;
          w_enter_armed = 1'b1;
        end
      end
      S_ARMED: begin
        // An early press beats a simultaneous delay completion.
        if (w_react_rise) begin
          w_next       = S_FOUL;
          w_enter_foul = 1'b1;
        end else if (delay_done) begin
          w_next     = S_GO;
          w_enter_go = 1'b1;
        end
      end
      S_GO: begin
        // A press on the final count is still a valid reaction.
        if (w_react_rise) begin
          w_next      = S_RESULT;
          w_press_hit = 1'b1;
        end else if (r_count == LP_TIMEOUT) begin
          w_next      = S_RESULT;
          w_timed_out = 1'b1;
        end
      end
      S_RESULT, S_FOUL: begin
        if (w_start_rise) begin
          w_next        = S_ARMED;
          w_enter_armed = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Button history for edge detection.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      r_start_prev <= 1'b1;
      r_react_prev <= 1'b1;
    end else begin
      r_start_prev <= start_btn;
      r_react_prev <= react_btn;
    end
  end

  // Reaction counter: zero in the first GO cycle, stops once GO is left so it never passes the timeout.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_enter_go) begin
      r_count <= '0;
    end else if ((r_state == S_GO) && (w_next == S_GO)) begin
      r_count <= r_count + 14'd1;
    end
  end

  // Round results: cleared on every ARMED entry, set on the edge that ends the round.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      reaction_ms  <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else if (w_enter_armed) begin
      reaction_ms  <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else if (w_press_hit) begin
      reaction_ms  <= r_count;
      result_valid <= 1'b1;
    end else if (w_timed_out) begin
      reaction_ms  <= LP_TIMEOUT;
      result_valid <= 1'b1;
      timeout      <= 1'b1;
    end else if (w_enter_foul) begin
      foul         <= 1'b1;
    end
  end

  // Best time since reset; only genuine presses can improve it.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      best_ms <= LP_TIMEOUT;
    end else if (w_press_hit && (r_count < best_ms)) begin
      best_ms <= r_count;
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a behavioural 1501-edge delay generator.
module tb_reaction_timer_ctrl;

  logic        clk_1ms = 1'b0;
  logic        clk_en  = 1'b0;
  logic        reset   = 1'b0;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic        delay_done;
  logic        delay_start;
  logic        go_led;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic        foul;
  logic        timeout;
  logic [13:0] best_ms;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0] gen_cnt;
  logic        gen_done;
  logic        force_done = 1'b0;

  assign delay_done = gen_done | force_done;

  reaction_timer_ctrl #(.TIMEOUT_MS(9999)) dut (
    .clk_1ms      (clk_1ms),
    .reset        (reset),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .delay_done   (delay_done),
    .delay_start  (delay_start),
    .go_led       (go_led),
    .reaction_ms  (reaction_ms),
    .result_valid (result_valid),
    .foul         (foul),
    .timeout      (timeout),
    .best_ms      (best_ms),
    .state_dbg    (state_dbg)
  );

  always #5 if (clk_en) clk_1ms = ~clk_1ms;

  // Delay generator model: done after 1501 edges with delay_start high, cleared when it drops.
  always @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      gen_cnt  <= '0;
      gen_done <= 1'b0;
    end else if (!delay_start) begin
      gen_cnt  <= '0;
      gen_done <= 1'b0;
    end else if (gen_cnt == 11'd1500) begin
      gen_done <= 1'b1;
    end else begin
      gen_cnt <= gen_cnt + 11'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1ms);
    #1;
  endtask

  task automatic press_start(input string tag);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check({tag, "_state_armed"}, 32'(state_dbg), 32'd1);
    check({tag, "_delay_start"}, 32'(delay_start), 32'd1);
    check({tag, "_rv_clear"}, 32'(result_valid), 32'd0);
    check({tag, "_rms_clear"}, 32'(reaction_ms), 32'd0);
  endtask

  // Edges from ARMED entry to GO entry: 1501 to raise done plus one to act on it.
  task automatic wait_go(input string tag);
    int n;
    n = 0;
    while (!go_led && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_go_latency"}, 32'(n), 32'd1502);
  endtask

  // Full round pressing react at count k; best_exp is the expected best afterwards.
  task automatic round(input string tag, input int k, input int best_exp);
    press_start(tag);
    wait_go(tag);
    repeat (k) tick();
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check({tag, "_reaction"}, 32'(reaction_ms), 32'(k));
    check({tag, "_rv"}, 32'(result_valid), 32'd1);
    check({tag, "_go_off"}, 32'(go_led), 32'd0);
    check({tag, "_best"}, 32'(best_ms), 32'(best_exp));
    tick();
  endtask

  initial begin
    // Asynchronous reset with no clock running; start held through reset.
    start_btn = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_delay_start", 32'(delay_start), 32'd0);
    check("rst_go", 32'(go_led), 32'd0);
    check("rst_reaction", 32'(reaction_ms), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_foul", 32'(foul), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_best", 32'(best_ms), 32'd9999);
    clk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held_start_no_round", 32'(state_dbg), 32'd0);
    start_btn = 1'b0;
    tick();

    // Normal round at 250 ms.
    round("normal", 250, 250);
    check("normal_state", 32'(state_dbg), 32'd3);
    check("normal_timeout", 32'(timeout), 32'd0);

    // Foul: press ~700 cycles into ARMED.
    press_start("foul");
    repeat (700) tick();
    check("foul_no_go", 32'(go_led), 32'd0);
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("foul_flag", 32'(foul), 32'd1);
    check("foul_state", 32'(state_dbg), 32'd4);
    check("foul_delay_off", 32'(delay_start), 32'd0);
    check("foul_go_off", 32'(go_led), 32'd0);
    check("foul_best", 32'(best_ms), 32'd250);
    check("foul_rv", 32'(result_valid), 32'd0);
    repeat (3) tick();

    // Timeout: next start clears foul, no press.
    press_start("tmo");
    check("tmo_foul_clear", 32'(foul), 32'd0);
    wait_go("tmo");
    repeat (9999) tick();
    check("tmo_still_go", 32'(state_dbg), 32'd2);
    check("tmo_not_yet", 32'(timeout), 32'd0);
    tick();
    check("tmo_state", 32'(state_dbg), 32'd3);
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_reaction", 32'(reaction_ms), 32'd9999);
    check("tmo_rv", 32'(result_valid), 32'd1);
    check("tmo_best", 32'(best_ms), 32'd250);
    tick();

    // Press exactly on the last count is a valid reaction.
    press_start("edge");
    check("edge_tmo_clear", 32'(timeout), 32'd0);
    wait_go("edge");
    repeat (9999) tick();
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("edge_timeout", 32'(timeout), 32'd0);
    check("edge_reaction", 32'(reaction_ms), 32'd9999);
    check("edge_rv", 32'(result_valid), 32'd1);
    check("edge_best", 32'(best_ms), 32'd250);
    tick();

    // Reset mid-round at count 50.
    press_start("midrst");
    wait_go("midrst");
    repeat (50) tick();
    #3 reset = 1'b1;
    #1;
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_go", 32'(go_led), 32'd0);
    check("midrst_delay", 32'(delay_start), 32'd0);
    check("midrst_best", 32'(best_ms), 32'd9999);
    check("midrst_rv", 32'(result_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Best-time tracking.
    round("best400", 400, 400);
    round("best180", 180, 180);
    round("best300", 300, 180);

    // delay_done already high in ARMED with a press: foul wins.
    force_done = 1'b1;
    press_start("prio");
    react_btn = 1'b1;
    tick();
    react_btn = 1'b0;
    check("prio_state", 32'(state_dbg), 32'd4);
    check("prio_foul", 32'(foul), 32'd1);
    check("prio_go", 32'(go_led), 32'd0);
    force_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
